// File: rtl/trace_checker.sv
// trace_checker: compares a CPU commit stream against an expected trace held in a
// synchronous ROM. Prefetches records into a 2-entry FIFO, stops on the first
// divergence with a latched diagnostic, or flags pass once every record matched.
module trace_checker #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned REC_W  = 102
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   trace_len,
  input  logic              commit_valid,
  input  logic [31:0]       commit_pc,
  input  logic [31:0]       commit_inst,
  input  logic              commit_we,
  input  logic [4:0]        commit_waddr,
  input  logic [31:0]       commit_wdata,
  output logic              exp_rd_en,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [REC_W-1:0]  exp_rdata,
  output logic              ready,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        err_code,
  output logic [ADDR_W:0]   err_index,
  output logic [4:0]        err_fields,
  output logic [ADDR_W:0]   match_count
);

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  localparam logic [ADDR_W:0] IdxOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e           r_state, w_state_d;
  logic [ADDR_W:0]  r_len, r_rd_idx, r_match_count, r_err_index;
  logic [2:0]       r_err_code;
  logic [4:0]       r_err_fields;
  logic [REC_W-1:0] r_fifo [2];
  logic             r_wr_ptr, r_rd_ptr, r_inflight;
  logic [1:0]       r_count;

  logic [REC_W-1:0] w_head;
  logic             w_exp_we, w_cmt_we, w_both_we;
  logic [4:0]       w_mask;
  logic             w_latch, w_pop, w_err_set, w_rd_en, w_push;
  logic [2:0]       w_err_code;
  logic [ADDR_W:0]  w_err_index;
  logic [4:0]       w_err_fields;
  logic [2:0]       w_level;

  // Writes to $0 are architectural no-ops, so they compare as "no write".
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_exp_we  = w_head[37] & (w_head[36:32] != 5'd0);
  assign w_cmt_we  = commit_we & (commit_waddr != 5'd0);
  assign w_both_we = w_exp_we & w_cmt_we;
  assign w_mask    = {w_head[101:70] != commit_pc,
                      w_head[69:38] != commit_inst,
                      w_exp_we != w_cmt_we,
                      w_both_we & (w_head[36:32] != commit_waddr),
                      w_both_we & (w_head[31:0] != commit_wdata)};

  // Occupancy is taken after this cycle's pop so a compare every cycle never starves.
  assign w_push  = r_inflight;
  assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en = (r_state == StRun) && (w_level < 3'd2) && (r_rd_idx < r_len);

  assign exp_rd_en   = w_rd_en;
  assign exp_addr    = r_rd_idx[ADDR_W-1:0];
  assign ready       = (r_count != 2'd0);
  assign pass        = (r_state == StPass);
  assign fail        = (r_state == StFail);
  assign err_code    = r_err_code;
  assign err_index   = r_err_index;
  assign err_fields  = r_err_fields;
  assign match_count = r_match_count;

  // State register.
  always_ff @(posedge clk_in) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next state, compare decision and diagnostic selection.
  always_comb begin
    w_state_d    = r_state;
    w_latch      = 1'b0;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
    w_err_code   = 3'd0;
    w_err_index  = '0;
    w_err_fields = 5'd0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_latch   = 1'b1;
          w_state_d = (trace_len == '0) ? StPass : StRun;
        end
      end
      StRun: begin
        if (commit_valid) begin
          if (r_count == 2'd0) begin
            w_state_d   = StFail;
            w_err_set   = 1'b1;
            w_err_code  = 3'd2;
            w_err_index = r_match_count;
          end else if (w_mask != 5'd0) begin
            w_state_d    = StFail;
            w_err_set    = 1'b1;
            w_err_code   = 3'd1;
            w_err_index  = r_match_count;
            w_err_fields = w_mask;
          end else begin
            w_pop = 1'b1;
            if (r_match_count + IdxOne == r_len) w_state_d = StPass;
          end
        end
      end
      StPass: begin
        if (commit_valid) begin
          w_state_d   = StFail;
          w_err_set   = 1'b1;
          w_err_code  = 3'd3;
          w_err_index = r_len;
        end
      end
      StFail: ;
      default: w_state_d = StIdle;
    endcase
  end

  // Prefetch FIFO, indices, match counter and latched diagnostics.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_len         <= '0;
      r_rd_idx      <= '0;
      r_match_count <= '0;
      r_err_index   <= '0;
      r_err_code    <= 3'd0;
      r_err_fields  <= 5'd0;
      r_fifo[0]     <= '0;
      r_fifo[1]     <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_inflight    <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_latch) begin
        r_len         <= trace_len;
        r_rd_idx      <= '0;
        r_match_count <= '0;
        r_wr_ptr      <= 1'b0;
        r_rd_ptr      <= 1'b0;
        r_count       <= 2'd0;
      end else begin
        if (w_rd_en) r_rd_idx <= r_rd_idx + IdxOne;
        if (w_push) begin
          r_fifo[r_wr_ptr] <= exp_rdata;
          r_wr_ptr         <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr      <= ~r_rd_ptr;
          r_match_count <= r_match_count + IdxOne;
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
      if (w_err_set) begin
        r_err_code   <= w_err_code;
        r_err_index  <= w_err_index;
        r_err_fields <= w_err_fields;
      end
    end
  end

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: directed scenarios plus randomized traces checked
// against a record-by-record reference model.
module tb_trace_checker;

  localparam int ADDR_W = 10;
  localparam int REC_W  = 102;

  logic              clk = 1'b0;
  logic              reset, start, commit_valid, commit_we;
  logic [ADDR_W:0]   trace_len;
  logic [31:0]       commit_pc, commit_inst, commit_wdata;
  logic [4:0]        commit_waddr;
  logic              exp_rd_en, ready, pass, fail;
  logic [ADDR_W-1:0] exp_addr;
  logic [REC_W-1:0]  exp_rdata;
  logic [2:0]        err_code;
  logic [ADDR_W:0]   err_index, match_count;
  logic [4:0]        err_fields;

  logic [REC_W-1:0]  rom [0:1023];
  logic [REC_W-1:0]  cq [$];

  int n_total = 0;
  int n_bad   = 0;

  // Model results
  logic        m_pass, m_fail;
  logic [2:0]  m_code;
  logic [10:0] m_idx, m_mc;
  logic [4:0]  m_fields;

  trace_checker #(.ADDR_W(ADDR_W), .REC_W(REC_W)) dut (
    .clk_in(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_we(commit_we), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .exp_rd_en(exp_rd_en), .exp_addr(exp_addr), .exp_rdata(exp_rdata),
    .ready(ready), .pass(pass), .fail(fail), .err_code(err_code),
    .err_index(err_index), .err_fields(err_fields), .match_count(match_count)
  );

  always #5 clk = ~clk;

  // Synchronous expected-trace ROM, one cycle of read latency.
  always_ff @(posedge clk) begin
    if (exp_rd_en) exp_rdata <= rom[exp_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
    return {pc, inst, we, wa, wd};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    trace_len = 11'(len);
    tick(1);
    start     = 1'b0;
  endtask

  task automatic set_commit(input logic [REC_W-1:0] c);
    commit_valid = 1'b1;
    commit_pc    = c[101:70];
    commit_inst  = c[69:38];
    commit_we    = c[37];
    commit_waddr = c[36:32];
    commit_wdata = c[31:0];
  endtask

  task automatic drive_commit(input logic [REC_W-1:0] c);
    set_commit(c);
    tick(1);
    commit_valid = 1'b0;
  endtask

  // Expected outcome of a commit sequence, taken straight from the trace rules.
  task automatic run_model(input int len);
    int idx;
    logic st_pass, st_fail, ewe, cwe;
    logic [REC_W-1:0] e, c;
    logic [4:0] f;
    idx = 0; st_fail = 1'b0; st_pass = (len == 0);
    m_code = 3'd0; m_idx = '0; m_fields = 5'd0;
    for (int k = 0; k < cq.size(); k++) begin
      if (st_fail) break;
      c = cq[k];
      if (st_pass) begin
        st_pass = 1'b0; st_fail = 1'b1; m_code = 3'd3; m_idx = 11'(len);
      end else begin
        e = rom[idx];
        ewe = e[37] && (e[36:32] != 0);
        cwe = c[37] && (c[36:32] != 0);
        f[4] = (e[101:70] != c[101:70]);
        f[3] = (e[69:38] != c[69:38]);
        f[2] = (ewe != cwe);
        f[1] = ewe && cwe && (e[36:32] != c[36:32]);
        f[0] = ewe && cwe && (e[31:0] != c[31:0]);
        if (f != 0) begin
          st_fail = 1'b1; m_code = 3'd1; m_idx = 11'(idx); m_fields = f;
        end else begin
          idx++;
          if (idx == len) st_pass = 1'b1;
        end
      end
    end
    m_pass = st_pass; m_fail = st_fail; m_mc = 11'(idx);
  endtask

  task automatic load_addi(input int len);
    for (int i = 0; i < len; i++)
      rom[i] = mk(32'h0040_0000 + 32'(4 * i), 32'h2008_0000 | 32'(i + 1), 1'b1, 5'd8,
                  32'(i + 1));
  endtask

  task automatic random_run(input int iter);
    int len;
    bit clean;
    logic [REC_W-1:0] c;
    logic [4:0] wa;
    len   = $urandom_range(1, 12);
    clean = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < len; i++) begin
      wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rom[i] = mk($urandom, $urandom, 1'($urandom_range(0, 1)), wa, $urandom);
    end
    cq.delete();
    for (int i = 0; i < len; i++) begin
      c = rom[i];
      case ($urandom_range(clean ? 5 : 0, 11))
        0: c[101:70] = c[101:70] ^ (32'd1 << $urandom_range(0, 31));
        1: c[69:38]  = c[69:38] ^ (32'd1 << $urandom_range(0, 31));
        2: c[37]     = ~c[37];
        3: c[36:32]  = c[36:32] ^ 5'($urandom_range(1, 31));
        4: c[31:0]   = c[31:0] ^ 32'($urandom_range(1, 255));
        5: if (!c[37]) begin c[36:32] = 5'($urandom); c[31:0] = $urandom; end
        6: if (c[36:32] == 0) begin c[37] = ~c[37]; c[31:0] = $urandom; end
        default: ;
      endcase
      cq.push_back(c);
    end
    if ($urandom_range(0, 2) == 0) cq.push_back(rom[0]);
    run_model(len);
    do_reset();
    do_start(len);
    tick(2);
    for (int k = 0; k < cq.size(); k++) begin
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
      drive_commit(cq[k]);
    end
    tick(2);
    check($sformatf("rnd%0d.pass", iter), 64'(pass), 64'(m_pass));
    check($sformatf("rnd%0d.fail", iter), 64'(fail), 64'(m_fail));
    check($sformatf("rnd%0d.code", iter), 64'(err_code), 64'(m_code));
    check($sformatf("rnd%0d.idx", iter), 64'(err_index), 64'(m_idx));
    check($sformatf("rnd%0d.fields", iter), 64'(err_fields), 64'(m_fields));
    check($sformatf("rnd%0d.mc", iter), 64'(match_count), 64'(m_mc));
    check($sformatf("rnd%0d.rd_en", iter), 64'(exp_rd_en), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; trace_len = '0; commit_valid = 1'b0; commit_we = 1'b0;
    commit_pc = '0; commit_inst = '0; commit_waddr = '0; commit_wdata = '0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    tick(2);
    reset = 1'b1;
    check("rst.pass", 64'(pass), 64'd0);
    check("rst.fail", 64'(fail), 64'd0);
    check("rst.ready", 64'(ready), 64'd0);
    check("rst.rd_en", 64'(exp_rd_en), 64'd0);
    check("rst.mc", 64'(match_count), 64'd0);

    // Matching run with prefetch timing.
    load_addi(4);
    do_start(4);
    check("m.rd_en_s", 64'(exp_rd_en), 64'd1);
    check("m.addr_s", 64'(exp_addr), 64'd0);
    check("m.ready_s", 64'(ready), 64'd0);
    tick(1);
    check("m.ready_s1", 64'(ready), 64'd0);
    tick(1);
    check("m.ready_s2", 64'(ready), 64'd1);
    for (int i = 0; i < 3; i++) drive_commit(rom[i]);
    check("m.mc3", 64'(match_count), 64'd3);
    check("m.pass3", 64'(pass), 64'd0);
    drive_commit(rom[3]);
    check("m.pass", 64'(pass), 64'd1);
    check("m.fail", 64'(fail), 64'd0);
    check("m.mc", 64'(match_count), 64'd4);
    check("m.rd_en_end", 64'(exp_rd_en), 64'd0);

    // wdata mismatch on record 2.
    do_reset();
    rom[2] = mk(32'h0040_0008, 32'h2009_0005, 1'b1, 5'd9, 32'h5);
    do_start(4);
    tick(2);
    drive_commit(rom[0]);
    drive_commit(rom[1]);
    drive_commit(mk(32'h0040_0008, 32'h2009_0005, 1'b1, 5'd9, 32'h6));
    tick(1);
    check("wd.fail", 64'(fail), 64'd1);
    check("wd.code", 64'(err_code), 64'd1);
    check("wd.idx", 64'(err_index), 64'd2);
    check("wd.fields", 64'(err_fields), 64'b00001);
    check("wd.mc", 64'(match_count), 64'd2);
    drive_commit(rom[3]);
    check("wd.frozen_mc", 64'(match_count), 64'd2);

    // $0 normalisation.
    do_reset();
    rom[0] = mk(32'h100, 32'h0, 1'b0, 5'd0, 32'h0);
    rom[1] = mk(32'h104, 32'h0, 1'b0, 5'd0, 32'h0);
    do_start(2);
    tick(2);
    drive_commit(mk(32'h100, 32'h0, 1'b1, 5'd0, 32'hDEAD));
    check("z.mc", 64'(match_count), 64'd1);
    check("z.fail0", 64'(fail), 64'd0);
    drive_commit(mk(32'h104, 32'h0, 1'b1, 5'd3, 32'h0));
    check("z.fields", 64'(err_fields), 64'b00100);
    check("z.idx", 64'(err_index), 64'd1);

    // Underrun: commit before any record has arrived.
    do_reset();
    load_addi(2);
    do_start(2);
    tick(1);
    drive_commit(rom[0]);
    check("u.fail", 64'(fail), 64'd1);
    check("u.code", 64'(err_code), 64'd2);
    check("u.idx", 64'(err_index), 64'd0);

    // Overrun after a one-record trace.
    do_reset();
    do_start(1);
    tick(2);
    drive_commit(rom[0]);
    check("o.pass", 64'(pass), 64'd1);
    drive_commit(rom[1]);
    check("o.fail", 64'(fail), 64'd1);
    check("o.code", 64'(err_code), 64'd3);
    check("o.idx", 64'(err_index), 64'd1);

    // Reset during record 3, then an empty trace.
    do_reset();
    load_addi(4);
    do_start(4);
    tick(2);
    for (int i = 0; i < 3; i++) drive_commit(rom[i]);
    set_commit(rom[3]);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    commit_valid = 1'b0;
    check("r.pass", 64'(pass), 64'd0);
    check("r.fail", 64'(fail), 64'd0);
    check("r.mc", 64'(match_count), 64'd0);
    check("r.code", 64'(err_code), 64'd0);
    check("r.ready", 64'(ready), 64'd0);
    check("r.rd_en", 64'(exp_rd_en), 64'd0);
    tick(2);
    check("r.rd_en_idle", 64'(exp_rd_en), 64'd0);
    do_start(0);
    check("r.pass0", 64'(pass), 64'd1);
    check("r.rd_en0", 64'(exp_rd_en), 64'd0);

    for (int it = 0; it < 40; it++) random_run(it);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
# trace_checker

Hardware commit-trace checker that sits beside `sccomp_dataflow` in simulation and FPGA self-test builds. It reads an expected instruction trace (pc, inst, register write-back) from a synchronous expected-trace ROM. It compares that trace record-by-record against the CPU's live commit stream. It stops on the first divergence, latches a diagnostic, or reports pass once the whole trace has matched.

## Interface
Parameters:
- `ADDR_W`, 10: expected-trace ROM address width; max trace length 2^ADDR_W records.
- `REC_W`, 102: record width, packed {pc[101:70], inst[69:38], we[37], waddr[36:32], wdata[31:0]}.

Ports:
- `clk_in` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: one-cycle pulse; latches `trace_len` and begins prefetch; ignored outside IDLE.
- `trace_len` in ADDR_W+1: number of expected records (0 allowed).
- `commit_valid` in 1: CPU retired one instruction this cycle.
- `commit_pc`, `commit_inst` in 32 each: retired pc / instruction.
- `commit_we` in 1, `commit_waddr` in 5, `commit_wdata` in 32: register-file write of the retired instruction.
- `exp_rd_en` out 1, `exp_addr` out ADDR_W: ROM read request.
- `exp_rdata` in REC_W: ROM data, valid the cycle after the request.
- `ready` out 1: prefetch buffer non-empty (commits may be checked).
- `pass`, `fail` out 1: sticky result flags.
- `err_code` out 3: 0 none, 1 field mismatch, 2 underrun, 3 overrun.
- `err_index` out ADDR_W+1: record index of the failing commit.
- `err_fields` out 5: mismatch mask {pc, inst, we, waddr, wdata}.
- `match_count` out ADDR_W+1: commits matched so far.

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE. All outputs 0; buffer, counters and in-flight flag cleared.
- IDLE + `start`: latch `trace_len` into `len_q`; zero read and compare indices. If `trace_len`==0 → PASS, else → RUN.
- Prefetch: 2-entry FIFO plus 1 in-flight flag. Issue `exp_rd_en`=1 with `exp_addr`=read index when (fifo count + in-flight) < 2 and read index < `len_q`. Read index increments on issue. Returned data is pushed the following cycle.
- Compare (RUN, `commit_valid`=1):
  - Normalisation, both sides: we'=we & (waddr!=0); waddr/wdata are compared only when both we'=1.
  - Fields: pc, inst and we' are always compared. waddr and wdata are compared when we' is set on both sides.
  - All equal: pop, increment `match_count`. If `match_count`+1 == `len_q` → PASS.
  - Any field differs → FAIL, err_code 1, `err_fields` per field, `err_index`=compare index.
  - FIFO empty at a commit → FAIL, err_code 2.
- PASS + `commit_valid` → FAIL, err_code 3, `err_index`=`len_q`.
- PASS/FAIL are terminal until reset. `start` there is ignored. FAIL freezes `match_count` and all diagnostics.
- `commit_valid`=0 in RUN: no compare; prefetch continues.
- Reset mid-RUN: next edge returns to IDLE. A read data return in that cycle is discarded.

## Timing
- ROM latency: request at edge t, `exp_rdata` captured at edge t+1.
- After `start` (edge s): first request at edge s+1; `ready`=1 from edge s+2; FIFO full by edge s+3.
- In steady state, sustains one compare per cycle indefinitely (single-cycle CPU rate).
- Compare result latency 1: commit sampled at edge c; `pass`/`fail`/`err_*`/`match_count` update at edge c, visible in cycle c+1.
- Simultaneous push and pop in one cycle: count unchanged, order preserved.
- Last record: no requests once read index == `len_q`. `exp_rd_en` stays 0 in IDLE/PASS/FAIL.

## Test plan
- Matching run: trace_len=4, ROM holds pc 0x00400000..0x0040000C with addi writes ($8←1..4), start, then 4 matching commits back-to-back from cycle s+3 → pass=1 one cycle after 4th, match_count=4, fail=0.
- wdata mismatch: record 2 expects $9←0x5, CPU commits $9←0x6 → fail=1, err_code=1, err_index=2, err_fields=5'b00001, match_count=2.
- $0 normalisation: expected we=0, commit we=1 waddr=0 wdata=0xDEAD → counts as match; commit we=1 waddr=3 → err_fields=5'b00100.
- Underrun: commit_valid at cycle s+1 (before ready) → fail, err_code=2, err_index=0. Overrun: trace_len=1 matched, extra commit → err_code=3, err_index=1.
- Reset mid-run: reset=0 for one cycle during record 3 → all outputs 0, state IDLE, exp_rd_en=0. Fresh start with trace_len=0 → pass=1 in cycle after start.
